// File: rtl/commit_buffer_pkg.sv
// Shared types for the in-order commit buffer.
// Result bundles arrive from the result queue; ResultKind selects the retire action.
package commit_buffer_pkg;

  localparam int REG_W = 6;

  typedef logic [7:0] w8;
  typedef logic [7:0] r8;

  typedef enum logic [1:0] {
    K_NONE,
    K_REG,
    K_BR_MISS
  } ResultKind;

  typedef struct packed {
    logic      en;
    w8         commit_id;
    ResultKind kind;
    logic [31:0] content;
  } Result;

endpackage

// File: rtl/commit_slot_ram.sv
// Per-slot payload store: dest written at alloc, kind+data written at complete.
// Split arrays give two independent write ports and one async read at head.
module commit_slot_ram
  import commit_buffer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_dest_we,
  input  logic [AW-1:0]    i_dest_addr,
  input  logic [REG_W-1:0] i_dest,
  input  logic             i_res_we,
  input  logic [AW-1:0]    i_res_addr,
  input  ResultKind        i_kind,
  input  logic [31:0]      i_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [REG_W-1:0] o_dest,
  output ResultKind        o_kind,
  output logic [31:0]      o_data
);

  logic [REG_W-1:0] r_dest [DEPTH];
  ResultKind        r_kind [DEPTH];
  logic [31:0]      r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (i_dest_we) r_dest[i_dest_addr] <= i_dest;
  end

  always_ff @(posedge clk) begin
    if (i_res_we) begin
      r_kind[i_res_addr] <= i_kind;
      r_data[i_res_addr] <= i_data;
    end
  end

  assign o_dest = r_dest[i_rd_addr];
  assign o_kind = r_kind[i_rd_addr];
  assign o_data = r_data[i_rd_addr];

endmodule

// File: rtl/commit_buffer.sv
// In-order retirement buffer: allocates ids, takes out-of-order results,
// retires in id order and flushes on a mispredicted branch.
module commit_buffer
  import commit_buffer_pkg::*;
#(
  parameter int ROB_SIZE = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [REG_W-1:0] alloc_dest,
  output logic             alloc_ready,
  output w8                alloc_id,
  input  Result            complete,
  output logic             commit_en,
  output w8                commit_id,
  output logic [REG_W-1:0] commit_dest,
  output logic [31:0]      commit_data,
  output logic             flash,
  output logic [31:0]      redirect_pc
);

  localparam int AW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [ROB_SIZE-1:0] r_done;

  logic             r_commit_en;
  w8                r_commit_id;
  logic [REG_W-1:0] r_commit_dest;
  logic [31:0]      r_commit_data;
  logic             r_flash;
  logic [31:0]      r_redirect_pc;

  logic             w_full;
  logic             w_alloc;
  logic [AW-1:0]    w_cid;
  logic [AW-1:0]    w_off;
  logic             w_inwin;
  logic             w_cmp;
  logic             w_retire;
  logic             w_miss;
  logic [REG_W-1:0] w_rd_dest;
  ResultKind        w_rd_kind;
  logic [31:0]      w_rd_data;
  logic             w_unused;

  assign w_full      = (r_count == CW'(ROB_SIZE));
  assign alloc_ready = ~w_full;
  assign alloc_id    = 8'(r_tail);

  // Slot index is the id modulo ROB_SIZE; upper id bits carry no state.
  assign w_cid    = complete.commit_id[AW-1:0];
  assign w_unused = ^complete.commit_id;
  assign w_off    = w_cid - r_head;
  assign w_inwin  = (CW'(w_off) < r_count);

  assign w_retire = (r_count != '0) & r_done[r_head] & ~r_flash;
  assign w_miss   = w_retire & (w_rd_kind == K_BR_MISS);
  assign w_alloc  = alloc_en & ~w_full & ~r_flash & ~w_miss;
  assign w_cmp    = complete.en & w_inwin & ~r_done[w_cid]
                  & ~r_flash & ~w_miss;

  commit_slot_ram #(
    .DEPTH (ROB_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk         (clock),
    .i_dest_we   (w_alloc),
    .i_dest_addr (r_tail),
    .i_dest      (alloc_dest),
    .i_res_we    (w_cmp),
    .i_res_addr  (w_cid),
    .i_kind      (complete.kind),
    .i_data      (complete.content),
    .i_rd_addr   (r_head),
    .o_dest      (w_rd_dest),
    .o_kind      (w_rd_kind),
    .o_data      (w_rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_done        <= '0;
      r_commit_en   <= 1'b0;
      r_commit_id   <= '0;
      r_commit_dest <= '0;
      r_commit_data <= '0;
      r_flash       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_commit_en <= w_retire;
      r_flash     <= w_miss;
      if (w_retire) begin
        r_commit_id   <= 8'(r_head);
        r_commit_dest <= (w_rd_kind == K_REG) ? w_rd_dest : '0;
        r_commit_data <= w_rd_data;
      end
      if (w_miss) begin
        r_redirect_pc <= w_rd_data;
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_done        <= '0;
      end else begin
        if (w_retire) begin
          r_head         <= r_head + 1'b1;
          r_done[r_head] <= 1'b0;
        end
        if (w_alloc) begin
          r_tail         <= r_tail + 1'b1;
          r_done[r_tail] <= 1'b0;
        end
        if (w_cmp) r_done[w_cid] <= 1'b1;
        r_count <= r_count + CW'(w_alloc) - CW'(w_retire);
      end
    end
  end

  assign commit_en   = r_commit_en;
  assign commit_id   = r_commit_id;
  assign commit_dest = r_commit_dest;
  assign commit_data = r_commit_data;
  assign flash       = r_flash;
  assign redirect_pc = r_redirect_pc;

endmodule
